dual_button_buzzer: RTL and testbench

- Front-panel input block: two independent debounced push-button channels (A, B), each producing a one-cycle trigger pulse on a debounced press.
- The triggers drive a buzzer/flash timer that asserts an indicator for a fixed number of cycles and records which button caused it.
- Sits between raw asynchronous board buttons and the control logic / LED / beeper outputs.

---
 rtl/dual_button_buzzer.sv | 110 +++++++++++
 tb/tb_dual_button_buzzer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dual_button_buzzer.sv
// rtl/dual_button_buzzer.sv - two debounced push-button channels driving a shared buzzer/flash timer
module dual_button_buzzer #(
  parameter int DEB_CMAX = 10,
  parameter int FLA_CMAX = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_a,
  input  logic a_b,
  input  logic lock_a,
  input  logic lock_b,
  output logic tr_a,
  output logic tr_b,
  output logic buz,
  output logic src_a,
  output logic src_b
);

  localparam int DW = (DEB_CMAX > 1) ? $clog2(DEB_CMAX) : 1;
  localparam int FW = $clog2(FLA_CMAX + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CMAX - 1);
  localparam logic [FW-1:0] FLA_LOAD = FW'(FLA_CMAX);

  logic [1:0] raw;
  logic [1:0] lock;
  logic [1:0] tr;

  assign raw  = {a_b, a_a};
  assign lock = {lock_b, lock_a};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic          stable_dd;
    logic [DW-1:0] cnt;
    logic          tr_q;

    // Any sample that agrees with the stable level restarts the count, so
    // only an unbroken run of DEB_CMAX differing samples flips the state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        stable    <= 1'b0;
        stable_d  <= 1'b0;
        stable_dd <= 1'b0;
        cnt       <= '0;
        tr_q      <= 1'b0;
      end else begin
        s1 <= raw[ch];
        s2 <= s1;
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
        stable_d  <= stable;
        stable_dd <= stable_d;
        tr_q      <= stable_d & ~stable_dd & ~lock[ch];
      end
    end

    assign tr[ch] = tr_q;
  end

  assign tr_a = tr[0];
  assign tr_b = tr[1];

  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  logic          fire;

  assign fire = tr_a | tr_b;

  always_comb begin
    fcnt_nxt = fcnt;
    if (fire) begin
      fcnt_nxt = FLA_LOAD;
    end else if (fcnt != '0) begin
      fcnt_nxt = fcnt - FW'(1);
    end
  end

  // buz and the source flags follow the next counter value so the flash
  // starts the cycle right after the trigger pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      buz   <= 1'b0;
      src_a <= 1'b0;
      src_b <= 1'b0;
    end else begin
      fcnt <= fcnt_nxt;
      buz  <= (fcnt_nxt != '0);
      if (fire) begin
        src_a <= tr_a;
        src_b <= tr_b;
      end else if (fcnt_nxt == '0) begin
        src_a <= 1'b0;
        src_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_button_buzzer.sv
// tb/tb_dual_button_buzzer.sv - scoreboard bench for dual_button_buzzer
module tb_dual_button_buzzer;

  localparam int DEB = 10;
  localparam int FLA = 500;
  localparam int LAT = DEB + 4;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_a = 1'b0;
  logic a_b = 1'b0;
  logic lock_a = 1'b0;
  logic lock_b = 1'b0;
  logic tr_a, tr_b, buz, src_a, src_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  ev_t  trq[$];
  ev_t  flq[$];
  int   mcnt = 0;
  logic msa = 1'b0;
  logic msb = 1'b0;

  dual_button_buzzer #(.DEB_CMAX(DEB), .FLA_CMAX(FLA)) dut (
    .clk(clk), .rst_n(rst_n), .a_a(a_a), .a_b(a_b),
    .lock_a(lock_a), .lock_b(lock_b),
    .tr_a(tr_a), .tr_b(tr_b), .buz(buz), .src_a(src_a), .src_b(src_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", tag, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A level driven now is first sampled at the next edge; the pulse lands LAT cycles on.
  task automatic expect_press(input logic a, input logic b);
    ev_t e;
    e.cyc = cyc + LAT;
    e.a   = a;
    e.b   = b;
    trq.push_back(e);
    flq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic ea, eb;
      ev_t  e;
      ea = 1'b0;
      eb = 1'b0;
      if (trq.size() > 0 && trq[0].cyc == cyc) begin
        e  = trq.pop_front();
        ea = e.a;
        eb = e.b;
      end
      check("tr_a", tr_a, ea);
      check("tr_b", tr_b, eb);
      if (mcnt > 0) mcnt--;
      if (flq.size() > 0 && flq[0].cyc + 1 == cyc) begin
        e    = flq.pop_front();
        mcnt = FLA;
        msa  = e.a;
        msb  = e.b;
      end
      if (mcnt == 0) begin
        msa = 1'b0;
        msb = 1'b0;
      end
      check("buz", buz, mcnt != 0);
      check("src_a", src_a, msa);
      check("src_b", src_b, msb);
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_tr_a", tr_a, 1'b0);
    check("rst_tr_b", tr_b, 1'b0);
    check("rst_buz", buz, 1'b0);
    check("rst_src_a", src_a, 1'b0);
    check("rst_src_b", src_b, 1'b0);
    step(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(20);

    // clean press and release
    a_a = 1'b1; expect_press(1'b1, 1'b0);
    step(100);
    a_a = 1'b0;
    step(600);

    // bounce shorter than the debounce window, then a settled press
    for (int i = 0; i < 10; i++) begin
      a_a = 1'b1; step(5);
      a_a = 1'b0; step(5);
    end
    a_a = 1'b1; expect_press(1'b1, 1'b0);
    step(100);
    a_a = 1'b0;
    step(600);

    // separate flashes A then B
    a_a = 1'b1; expect_press(1'b1, 1'b0);
    step(50);
    a_a = 1'b0;
    step(950);
    a_b = 1'b1; expect_press(1'b0, 1'b1);
    step(50);
    a_b = 1'b0;
    step(600);

    // B retriggers 300 cycles into A's flash
    a_a = 1'b1; expect_press(1'b1, 1'b0);
    step(50);
    a_a = 1'b0;
    step(250);
    a_b = 1'b1; expect_press(1'b0, 1'b1);
    step(50);
    a_b = 1'b0;
    step(600);

    // simultaneous press
    a_a = 1'b1; a_b = 1'b1; expect_press(1'b1, 1'b1);
    step(50);
    a_a = 1'b0; a_b = 1'b0;
    step(600);

    // press completing under lock is dropped; next press works
    lock_a = 1'b1; a_a = 1'b1;
    step(50);
    lock_a = 1'b0;
    step(20);
    a_a = 1'b0;
    step(30);
    a_a = 1'b1; expect_press(1'b1, 1'b0);
    step(50);
    a_a = 1'b0;
    step(100);

    // asynchronous reset mid-flash
    @(posedge clk);
    #3 rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check("mid_rst_tr_a", tr_a, 1'b0);
    check("mid_rst_tr_b", tr_b, 1'b0);
    check("mid_rst_buz", buz, 1'b0);
    check("mid_rst_src_a", src_a, 1'b0);
    check("mid_rst_src_b", src_b, 1'b0);
    trq.delete();
    flq.delete();
    mcnt = 0;
    msa  = 1'b0;
    msb  = 1'b0;
    step(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(50);

    mon_en = 1'b0;
    check("scoreboard_drained", trq.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
